// File: rtl/sound_wave_ram.sv
// Channel-3 wave pattern RAM with CPU/channel access arbitration.
// Define WAVE_DMG_WINDOW_EN for the DMG access-window model (CGB model otherwise).
module sound_wave_ram #(
  parameter int WINDOW_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [7:0] din,
  input  logic       wr,
  input  logic       rd,
  output logic [7:0] dout,
  input  logic       ch_on,
  input  logic [3:0] wave_a,
  input  logic       fetch,
  output logic [7:0] wave_d
);

`ifdef WAVE_DMG_WINDOW_EN
  localparam bit DMG_WINDOW = 1'b1;
`else
  localparam bit DMG_WINDOW = 1'b0;
`endif

  localparam logic [3:0] WIN_LD = 4'(WINDOW_CYCLES);

  logic [7:0] mem [16];
  logic [3:0] last_a;
  logic [3:0] win_cnt;

  logic [3:0] ea;
  logic       win_open;
  logic       cpu_ok;
  logic       cpu_wr;
  logic       cpu_rd;
  logic       fwd;

  // last_a is the pre-fetch value here, so a same-cycle fetch never
  // redirects the CPU access it coincides with.
  assign ea       = ch_on ? last_a : a;
  assign win_open = (win_cnt != 4'd0);
  assign cpu_ok   = !ch_on || !DMG_WINDOW || win_open;
  assign cpu_wr   = wr && cpu_ok && !rst;
  assign cpu_rd   = rd && cpu_ok;
  assign fwd      = cpu_wr && (ea == wave_a);

  always_ff @(posedge clk) begin
    if (cpu_wr) begin
      mem[ea] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= 8'hFF;
    end else if (rd) begin
      dout <= cpu_rd ? mem[ea] : 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wave_d <= 8'h00;
      last_a <= 4'd0;
    end else if (fetch) begin
      wave_d <= fwd ? din : mem[wave_a];
      last_a <= wave_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= 4'd0;
    end else if (fetch) begin
      win_cnt <= WIN_LD;
    end else if (win_open) begin
      win_cnt <= win_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_sound_wave_ram.sv
// Scoreboard bench for sound_wave_ram: directed vectors, queued expectations.
module tb_sound_wave_ram;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [7:0] din;
  logic       wr;
  logic       rd;
  logic [7:0] dout;
  logic       ch_on;
  logic [3:0] wave_a;
  logic       fetch;
  logic [7:0] wave_d;

  logic peek;
  logic rd_q, fetch_q, rst_q, peek_q;

  int tests  = 0;
  int errors = 0;

  logic [7:0] exp_dout [$];
  logic [7:0] exp_wave [$];
  string      tag_dout [$];
  string      tag_wave [$];

  sound_wave_ram #(.WINDOW_CYCLES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .din    (din),
    .wr     (wr),
    .rd     (rd),
    .dout   (dout),
    .ch_on  (ch_on),
    .wave_a (wave_a),
    .fetch  (fetch),
    .wave_d (wave_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    rd_q    <= rd && !rst;
    fetch_q <= fetch && !rst;
    peek_q  <= peek && !rst;
    rst_q   <= rst;
  end

  task automatic chk_dout();
    tests++;
    if (exp_dout.size() == 0) begin
      errors++;
      $display("FAIL dout_unexpected: got %02h, no expectation", dout);
    end else begin
      logic [7:0] e;
      string t;
      e = exp_dout.pop_front();
      t = tag_dout.pop_front();
      if (dout !== e) begin
        errors++;
        $display("FAIL %s: dout=%02h expected %02h", t, dout, e);
      end
    end
  endtask

  task automatic chk_wave();
    tests++;
    if (exp_wave.size() == 0) begin
      errors++;
      $display("FAIL wave_unexpected: got %02h, no expectation", wave_d);
    end else begin
      logic [7:0] e;
      string t;
      e = exp_wave.pop_front();
      t = tag_wave.pop_front();
      if (wave_d !== e) begin
        errors++;
        $display("FAIL %s: wave_d=%02h expected %02h", t, wave_d, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_q) begin
      chk_dout();
      chk_wave();
    end else begin
      if (rd_q) chk_dout();
      if (fetch_q || peek_q) chk_wave();
    end
  end

  task automatic ed(input logic [7:0] v, input string t);
    exp_dout.push_back(v);
    tag_dout.push_back(t);
  endtask

  task automatic ew(input logic [7:0] v, input string t);
    exp_wave.push_back(v);
    tag_wave.push_back(t);
  endtask

  task automatic cyc(input logic r, input logic w, input logic [3:0] aa,
                     input logic [7:0] dd, input logic co, input logic f,
                     input logic [3:0] wa, input logic pk);
    rd     = r;
    wr     = w;
    a      = aa;
    din    = dd;
    ch_on  = co;
    fetch  = f;
    wave_a = wa;
    peek   = pk;
    @(posedge clk);
    #1;
    rd    = 1'b0;
    wr    = 1'b0;
    fetch = 1'b0;
    peek  = 1'b0;
  endtask

  task automatic idle(input logic co);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, co, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    ed(8'hFF, "rst_dout");
    ew(8'h00, "rst_wave");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; a = '0; din = '0; wr = 1'b0; rd = 1'b0;
    ch_on = 1'b0; wave_a = '0; fetch = 1'b0; peek = 1'b0;
    #1;
    do_reset();
    idle(1'b0);

    // T1: fill and read back with ch_on=0
    for (int k = 0; k < 16; k++)
      cyc(1'b0, 1'b1, 4'(k), 8'h10 + 8'(k), 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      ed(8'h10 + 8'(k), "t1_read");
      cyc(1'b1, 1'b0, 4'(k), 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    end
    idle(1'b0);

    // T2: fetch, then write; wave_d holds
    ew(8'h15, "t2_fetch");
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 4'd5, 1'b0);
    cyc(1'b0, 1'b1, 4'd5, 8'hAB, 1'b0, 1'b0, 4'd0, 1'b0);
    ew(8'h15, "t2_hold");
    ed(8'hAB, "t2_mem5");
    cyc(1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1);

    // T3: same-cycle fetch and write forwarding
    ew(8'h5A, "t3_fwd");
    cyc(1'b0, 1'b1, 4'd3, 8'h5A, 1'b0, 1'b1, 4'd3, 1'b0);
    ed(8'h5A, "t3_mem3");
    cyc(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);

    // read-first on simultaneous rd/wr
    ed(8'h14, "rw_readfirst");
    cyc(1'b1, 1'b1, 4'd4, 8'h77, 1'b0, 1'b0, 4'd0, 1'b0);
    ed(8'h77, "rw_written");
    cyc(1'b1, 1'b0, 4'd4, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);

`ifndef WAVE_DMG_WINDOW_EN
    // T4: CGB redirect to last_a
    ew(8'h19, "t4_fetch");
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd9, 1'b0);
    ed(8'h19, "t4_redirect_rd");
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 1'b1, 4'd0, 8'hC3, 1'b1, 1'b0, 4'd0, 1'b0);
    ed(8'hC3, "t4_mem9");
    cyc(1'b1, 1'b0, 4'd9, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    ed(8'h10, "t4_mem0");
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);

    // fetch + CPU read same cycle uses old last_a
    ew(8'h12, "old_last_fetch");
    ed(8'hC3, "old_last_rd");
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd2, 1'b0);
    ed(8'h12, "new_last_rd");
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0);

    // T6: reset mid-stream; storage survives, last_a cleared
    do_reset();
    ed(8'hC3, "t6_mem9");
    cyc(1'b1, 1'b0, 4'd9, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    ed(8'h10, "t6_last_a0");
    cyc(1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0);
`else
    // T5: DMG access window
    ew(8'h17, "t5_fetch");
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd7, 1'b0);
    ed(8'h17, "t5_in_window");
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0);
    idle(1'b1);
    ed(8'hFF, "t5_out_window");
    cyc(1'b1, 1'b1, 4'd0, 8'hEE, 1'b1, 1'b0, 4'd0, 1'b0);
    ed(8'h17, "t5_wr_dropped");
    cyc(1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);

    do_reset();
    ed(8'h17, "t6_mem7");
    cyc(1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    ed(8'hFF, "t6_closed");
    cyc(1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0);
`endif

    for (int i = 0; i < 4; i++) idle(1'b0);

    if (exp_dout.size() != 0 || exp_wave.size() != 0) begin
      tests++;
      errors++;
      $display("FAIL drain: %0d dout and %0d wave expectations left, expected 0",
               exp_dout.size(), exp_wave.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
